if_stage: RTL and testbench

- Instruction-fetch stage of the RV32I pipeline; sits directly upstream of the combinational instruction memory.
- Owns the PC and drives the memory address each cycle.
- Captures the returned instruction into the IF/ID pipeline register.
- Applies stall, flush and branch/jump redirect from the hazard unit and EX stage, inserting NOP bubbles where required.

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_pc_gen.sv | 47 ++++
 rtl/if_stage.sv | 126 ++++++++++++
 tb/tb_if_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the RV32I instruction-fetch stage
package if_pkg;

    localparam logic [31:0] IF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] IF_NOP_INSTR    = 32'h0000_0013;

    typedef enum logic {
        BOOT,
        RUN
    } if_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        misalign;
    } if_id_t;

endpackage

// File: rtl/if_pc_gen.sv
// rtl/if_pc_gen.sv - program counter with redirect/stall priority and misaligned-target tracking
module if_pc_gen
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = IF_RESET_VECTOR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        mis_o
);

    logic [31:0] pc_q, pc_d;
    logic        mis_q, mis_d;

    assign pc_o  = pc_q;
    assign pc4_o = pc_q + 32'd4;
    assign mis_o = mis_q;

    // mis_q follows the slot at pc_q: it is consumed whenever the PC moves on.
    always_comb begin
        pc_d  = pc_q;
        mis_d = mis_q;
        if (redirect_i) begin
            pc_d  = {redirect_pc_i[31:2], 2'b00};
            mis_d = |redirect_pc_i[1:0];
        end else if (!stall_i) begin
            pc_d  = pc4_o;
            mis_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q  <= RESET_VECTOR;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I fetch stage with IF/ID register; IF_PERF_CNT_EN adds fetch/bubble counters
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = IF_RESET_VECTOR,
    parameter logic [31:0] NOP_INSTR    = IF_NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] instruct_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc4_o,
    output logic [31:0] if_instr_o,
    output logic        if_valid_o,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o,
`endif
    output logic        if_misalign_o
);

    logic [31:0] pc, pc4;
    logic        mis;
    if_id_t      if_id_q, if_id_d;
    if_state_e   state_q;
    logic        load_fetch, load_bubble;

    if_pc_gen #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_gen (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc),
        .pc4_o         (pc4),
        .mis_o         (mis)
    );

    assign imem_addr_o = pc;

    always_comb begin
        if_id_d     = if_id_q;
        load_fetch  = 1'b0;
        load_bubble = 1'b0;
        if (redirect_i || flush_i) begin
            if_id_d.instr    = NOP_INSTR;
            if_id_d.valid    = 1'b0;
            if_id_d.misalign = 1'b0;
            load_bubble      = 1'b1;
        end else if (!stall_i) begin
            if_id_d.pc  = pc;
            if_id_d.pc4 = pc4;
            if (mis) begin
                if_id_d.instr    = NOP_INSTR;
                if_id_d.valid    = 1'b0;
                if_id_d.misalign = 1'b1;
                load_bubble      = 1'b1;
            end else begin
                if_id_d.instr    = instruct_i;
                if_id_d.valid    = 1'b1;
                if_id_d.misalign = 1'b0;
                load_fetch       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            if_id_q <= '{instr: NOP_INSTR, pc: 32'd0, pc4: 32'd4, valid: 1'b0, misalign: 1'b0};
        end else begin
            if_id_q <= if_id_d;
        end
    end

    // BOOT only marks the first post-reset cycle; the datapath treats it like RUN.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= BOOT;
        end else begin
            case (state_q)
                BOOT:    state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign if_pc_o       = if_id_q.pc;
    assign if_pc4_o      = if_id_q.pc4;
    assign if_instr_o    = if_id_q.instr;
    assign if_valid_o    = if_id_q.valid;
    assign if_misalign_o = if_id_q.misalign;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {31'd0, load_fetch};
        bubble_cnt_d = bubble_cnt_q + {31'd0, load_bubble};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = load_fetch ^ load_bubble;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage (counter checks when IF_PERF_CNT_EN is defined)
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        stall_i, flush_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] instruct_i;
    logic [31:0] if_pc_o, if_pc4_o, if_instr_o;
    logic        if_valid_o, if_misalign_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_o, bubble_cnt_o;
`endif

    logic [31:0] mem [0:63];

    typedef struct {
        logic        st, fl, rd;
        logic [31:0] tgt;
        logic        ev, em;
        logic [31:0] epc, einstr;
        logic        chk;
        logic [31:0] eaddr;
    } row_t;

    row_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    assign instruct_i = mem[imem_addr_o[7:2]];

    if_stage dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .instruct_i    (instruct_i),
        .if_pc_o       (if_pc_o),
        .if_pc4_o      (if_pc4_o),
        .if_instr_o    (if_instr_o),
        .if_valid_o    (if_valid_o),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt_o   (fetch_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o),
`endif
        .if_misalign_o (if_misalign_o)
    );

    task automatic tick(input logic st, input logic fl, input logic rd, input logic [31:0] tgt);
        stall_i       = st;
        flush_i       = fl;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        rst_ni = 1'b1;
    endtask

    task automatic push_row(input logic st, input logic fl, input logic rd, input logic [31:0] tgt,
                            input logic ev, input logic em, input logic [31:0] epc,
                            input logic [31:0] einstr, input logic chk, input logic [31:0] eaddr);
        row_t r;
        r.st = st; r.fl = fl; r.rd = rd; r.tgt = tgt;
        r.ev = ev; r.em = em; r.epc = epc; r.einstr = einstr; r.chk = chk; r.eaddr = eaddr;
        exp_q.push_back(r);
    endtask

    task automatic test_reset();
        row_t r;
        logic [31:0] gp, gp4, wp, wp4;
        int beat = 0;
        rst_ni = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++; if (if_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", if_valid_o); else n_pass++;
        n_checks++; if (if_instr_o !== NOP) $display("FAIL reset_instr: got %h expected %h", if_instr_o, NOP); else n_pass++;
        n_checks++; if (if_pc_o !== 32'd0) $display("FAIL reset_pc: got %h expected 0", if_pc_o); else n_pass++;
        n_checks++; if (if_pc4_o !== 32'd4) $display("FAIL reset_pc4: got %h expected 4", if_pc4_o); else n_pass++;
        n_checks++; if (if_misalign_o !== 1'b0) $display("FAIL reset_mis: got %b expected 0", if_misalign_o); else n_pass++;
        n_checks++; if (imem_addr_o !== 32'd0) $display("FAIL reset_addr: got %h expected 0", imem_addr_o); else n_pass++;
`ifdef IF_PERF_CNT_EN
        n_checks++; if (fetch_cnt_o !== 32'd0) $display("FAIL reset_fetch_cnt: got %0d expected 0", fetch_cnt_o); else n_pass++;
        n_checks++; if (bubble_cnt_o !== 32'd0) $display("FAIL reset_bubble_cnt: got %0d expected 0", bubble_cnt_o); else n_pass++;
`endif
        rst_ni = 1'b1;
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h0, mem[0], 1, 32'h4);
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h4, mem[1], 1, 32'h8);
        push_row(0, 0, 1, 32'h42, 0, 0, 32'h0, NOP, 0, 32'h40);
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            tick(r.st, r.fl, r.rd, r.tgt);
            gp = r.chk ? if_pc_o : 32'h0;  gp4 = r.chk ? if_pc4_o : 32'h0;
            wp = r.chk ? r.epc : 32'h0;    wp4 = r.chk ? r.epc + 32'd4 : 32'h0;
            n_checks++;
            if ({if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o} !== {r.ev, r.em, r.einstr, wp, wp4, r.eaddr})
                $display("FAIL reset_seq beat %0d: got v=%b m=%b instr=%h pc=%h pc4=%h addr=%h expected v=%b m=%b instr=%h pc=%h pc4=%h addr=%h",
                         beat, if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o, r.ev, r.em, r.einstr, wp, wp4, r.eaddr);
            else n_pass++;
            beat++;
        end
        // reset with a misaligned redirect pending: it must not survive
        rst_ni = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        rst_ni = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if ({if_valid_o, if_misalign_o, if_pc_o, if_instr_o, imem_addr_o} !== {1'b1, 1'b0, 32'h0, mem[0], 32'h4})
            $display("FAIL reset_midop: got v=%b m=%b pc=%h instr=%h addr=%h expected v=1 m=0 pc=0 instr=%h addr=4",
                     if_valid_o, if_misalign_o, if_pc_o, if_instr_o, imem_addr_o, mem[0]);
        else n_pass++;
    endtask

    task automatic test_stall();
        row_t r;
        logic [31:0] gp, gp4, wp, wp4;
        int beat = 0;
        do_reset();
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h0, mem[0], 1, 32'h4);
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h4, mem[1], 1, 32'h8);
        for (int i = 0; i < 3; i++) push_row(1, 0, 0, 32'h0, 1, 0, 32'h4, mem[1], 1, 32'h8);
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h8, mem[2], 1, 32'hC);
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            tick(r.st, r.fl, r.rd, r.tgt);
            gp = r.chk ? if_pc_o : 32'h0;  gp4 = r.chk ? if_pc4_o : 32'h0;
            wp = r.chk ? r.epc : 32'h0;    wp4 = r.chk ? r.epc + 32'd4 : 32'h0;
            n_checks++;
            if ({if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o} !== {r.ev, r.em, r.einstr, wp, wp4, r.eaddr})
                $display("FAIL stall beat %0d: got v=%b m=%b instr=%h pc=%h pc4=%h addr=%h expected v=%b m=%b instr=%h pc=%h pc4=%h addr=%h",
                         beat, if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o, r.ev, r.em, r.einstr, wp, wp4, r.eaddr);
            else n_pass++;
            beat++;
        end
    endtask

    task automatic test_redirect();
        row_t r;
        logic [31:0] gp, gp4, wp, wp4;
        int beat = 0;
        do_reset();
        for (int i = 0; i < 4; i++) push_row(0, 0, 0, 32'h0, 1, 0, 32'(4 * i), mem[i], 1, 32'(4 * i + 4));
        push_row(0, 0, 1, 32'h40, 0, 0, 32'h0, NOP, 0, 32'h40);
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h40, mem[16], 1, 32'h44);
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h44, mem[17], 1, 32'h48);
        // redirect beats stall
        push_row(1, 0, 1, 32'h20, 0, 0, 32'h0, NOP, 0, 32'h20);
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h20, mem[8], 1, 32'h24);
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            tick(r.st, r.fl, r.rd, r.tgt);
            gp = r.chk ? if_pc_o : 32'h0;  gp4 = r.chk ? if_pc4_o : 32'h0;
            wp = r.chk ? r.epc : 32'h0;    wp4 = r.chk ? r.epc + 32'd4 : 32'h0;
            n_checks++;
            if ({if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o} !== {r.ev, r.em, r.einstr, wp, wp4, r.eaddr})
                $display("FAIL redirect beat %0d: got v=%b m=%b instr=%h pc=%h pc4=%h addr=%h expected v=%b m=%b instr=%h pc=%h pc4=%h addr=%h",
                         beat, if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o, r.ev, r.em, r.einstr, wp, wp4, r.eaddr);
            else n_pass++;
            beat++;
        end
    endtask

    task automatic test_misalign();
        row_t r;
        logic [31:0] gp, gp4, wp, wp4;
        int beat = 0;
        do_reset();
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h0, mem[0], 1, 32'h4);
        push_row(0, 0, 1, 32'h42, 0, 0, 32'h0, NOP, 0, 32'h40);
        push_row(0, 0, 0, 32'h0, 0, 1, 32'h0, NOP, 0, 32'h44);
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h44, mem[17], 1, 32'h48);
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            tick(r.st, r.fl, r.rd, r.tgt);
            gp = r.chk ? if_pc_o : 32'h0;  gp4 = r.chk ? if_pc4_o : 32'h0;
            wp = r.chk ? r.epc : 32'h0;    wp4 = r.chk ? r.epc + 32'd4 : 32'h0;
            n_checks++;
            if ({if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o} !== {r.ev, r.em, r.einstr, wp, wp4, r.eaddr})
                $display("FAIL misalign beat %0d: got v=%b m=%b instr=%h pc=%h pc4=%h addr=%h expected v=%b m=%b instr=%h pc=%h pc4=%h addr=%h",
                         beat, if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o, r.ev, r.em, r.einstr, wp, wp4, r.eaddr);
            else n_pass++;
            beat++;
        end
    endtask

    task automatic test_flush();
        row_t r;
        logic [31:0] gp, gp4, wp, wp4;
        int beat = 0;
        do_reset();
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h0, mem[0], 1, 32'h4);
        push_row(0, 1, 0, 32'h0, 0, 0, 32'h0, NOP, 0, 32'h8);
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h8, mem[2], 1, 32'hC);
        push_row(1, 1, 0, 32'h0, 0, 0, 32'h0, NOP, 0, 32'hC);
        push_row(0, 0, 0, 32'h0, 1, 0, 32'hC, mem[3], 1, 32'h10);
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            tick(r.st, r.fl, r.rd, r.tgt);
            gp = r.chk ? if_pc_o : 32'h0;  gp4 = r.chk ? if_pc4_o : 32'h0;
            wp = r.chk ? r.epc : 32'h0;    wp4 = r.chk ? r.epc + 32'd4 : 32'h0;
            n_checks++;
            if ({if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o} !== {r.ev, r.em, r.einstr, wp, wp4, r.eaddr})
                $display("FAIL flush beat %0d: got v=%b m=%b instr=%h pc=%h pc4=%h addr=%h expected v=%b m=%b instr=%h pc=%h pc4=%h addr=%h",
                         beat, if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o, r.ev, r.em, r.einstr, wp, wp4, r.eaddr);
            else n_pass++;
            beat++;
        end
    endtask

    task automatic test_back_to_back();
        row_t r;
        logic [31:0] gp, gp4, wp, wp4;
        int beat = 0;
        do_reset();
        push_row(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, NOP, 0, 32'hFFFF_FFFC);
        push_row(0, 0, 0, 32'h0, 1, 0, 32'hFFFF_FFFC, mem[63], 1, 32'h0);
        push_row(0, 0, 1, 32'h30, 0, 0, 32'h0, NOP, 0, 32'h30);
        push_row(0, 0, 1, 32'h18, 0, 0, 32'h0, NOP, 0, 32'h18);
        push_row(0, 0, 0, 32'h0, 1, 0, 32'h18, mem[6], 1, 32'h1C);
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            tick(r.st, r.fl, r.rd, r.tgt);
            gp = r.chk ? if_pc_o : 32'h0;  gp4 = r.chk ? if_pc4_o : 32'h0;
            wp = r.chk ? r.epc : 32'h0;    wp4 = r.chk ? r.epc + 32'd4 : 32'h0;
            n_checks++;
            if ({if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o} !== {r.ev, r.em, r.einstr, wp, wp4, r.eaddr})
                $display("FAIL back_to_back beat %0d: got v=%b m=%b instr=%h pc=%h pc4=%h addr=%h expected v=%b m=%b instr=%h pc=%h pc4=%h addr=%h",
                         beat, if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o, r.ev, r.em, r.einstr, wp, wp4, r.eaddr);
            else n_pass++;
            beat++;
        end
    endtask

    task automatic test_perf();
        row_t r;
        logic [31:0] gp, gp4, wp, wp4;
        int beat = 0;
        do_reset();
        for (int i = 0; i < 10; i++) push_row(0, 0, 0, 32'h0, 1, 0, 32'(4 * i), mem[i], 1, 32'(4 * i + 4));
        push_row(0, 0, 1, 32'h40, 0, 0, 32'h0, NOP, 0, 32'h40);
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            tick(r.st, r.fl, r.rd, r.tgt);
            gp = r.chk ? if_pc_o : 32'h0;  gp4 = r.chk ? if_pc4_o : 32'h0;
            wp = r.chk ? r.epc : 32'h0;    wp4 = r.chk ? r.epc + 32'd4 : 32'h0;
            n_checks++;
            if ({if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o} !== {r.ev, r.em, r.einstr, wp, wp4, r.eaddr})
                $display("FAIL perf beat %0d: got v=%b m=%b instr=%h pc=%h pc4=%h addr=%h expected v=%b m=%b instr=%h pc=%h pc4=%h addr=%h",
                         beat, if_valid_o, if_misalign_o, if_instr_o, gp, gp4, imem_addr_o, r.ev, r.em, r.einstr, wp, wp4, r.eaddr);
            else n_pass++;
            beat++;
        end
`ifdef IF_PERF_CNT_EN
        n_checks++; if (fetch_cnt_o !== 32'd10) $display("FAIL fetch_cnt: got %0d expected 10", fetch_cnt_o); else n_pass++;
        n_checks++; if (bubble_cnt_o !== 32'd1) $display("FAIL bubble_cnt: got %0d expected 1", bubble_cnt_o); else n_pass++;
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (32'(i + 1) << 12);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        rst_ni        = 1'b0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        #2;
        test_reset();
        test_stall();
        test_redirect();
        test_misalign();
        test_flush();
        test_back_to_back();
        test_perf();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
